// File: rtl/register_file_mp.sv
// Multi-port register file: NWR byte-masked write ports, NRD registered read ports,
// optional hardwired-zero r0, write-first or read-first forwarding, collision flag.
module register_file_mp #(
  parameter int unsigned NREGS   = 8,
  parameter int unsigned RSIZE   = 8,
  parameter int unsigned NRD     = 2,
  parameter int unsigned NWR     = 2,
  parameter int unsigned ZERO_R0 = 0,
  parameter int unsigned BYPASS  = 1,
  localparam int unsigned IW     = (NREGS > 1) ? $clog2(NREGS) : 1,
  localparam int unsigned NB     = RSIZE / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NWR-1:0]       we_i,
  input  logic [NWR*IW-1:0]    widx_i,
  input  logic [NWR*RSIZE-1:0] wd_i,
  input  logic [NWR*NB-1:0]    wbe_i,
  input  logic [NRD-1:0]       re_i,
  input  logic [NRD*IW-1:0]    ridx_i,
  output logic [NRD*RSIZE-1:0] rd_o,
  output logic [NRD-1:0]       rvalid_o,
  output logic                 wconflict_o
);

  logic [RSIZE-1:0]     regs_q [NREGS];
  logic [RSIZE-1:0]     regs_d [NREGS];
  logic [NWR-1:0]       wvalid;
  logic                 conflict_d;
  logic [NRD*RSIZE-1:0] rd_d;
  logic [NRD*RSIZE-1:0] rd_q;
  logic [NRD-1:0]       rvalid_q;
  logic                 wconflict_q;

  // A write counts only if its index exists and is not the hardwired-zero r0.
  function automatic logic idx_writable(input logic [IW-1:0] idx);
    logic in_range;
    logic is_zero;
    in_range = (32'(idx) < NREGS);
    is_zero  = (ZERO_R0 != 0) && (idx == '0);
    return in_range && !is_zero;
  endfunction

  // Ascending port order makes the highest-numbered port win each contested byte.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int p = 0; p < NWR; p++) begin
      wvalid[p] = we_i[p] && idx_writable(widx_i[p*IW +: IW]);
    end
    for (int p = 0; p < NWR; p++) begin
      for (int i = 0; i < NREGS; i++) begin
        if (wvalid[p] && (widx_i[p*IW +: IW] == IW'(i))) begin
          for (int b = 0; b < NB; b++) begin
            if (wbe_i[p*NB + b]) begin
              regs_d[i][b*8 +: 8] = wd_i[p*RSIZE + b*8 +: 8];
            end
          end
        end
      end
    end
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int p = 0; p < NWR; p++) begin
      for (int q = p + 1; q < NWR; q++) begin
        if (wvalid[p] && wvalid[q] && (widx_i[p*IW +: IW] == widx_i[q*IW +: IW]) &&
            ((wbe_i[p*NB +: NB] & wbe_i[q*NB +: NB]) != '0)) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  // Out-of-range indices match no register and so read as zero.
  always_comb begin
    rd_d = '0;
    for (int r = 0; r < NRD; r++) begin
      for (int i = 0; i < NREGS; i++) begin
        if ((ridx_i[r*IW +: IW] == IW'(i)) && !((ZERO_R0 != 0) && (i == 0))) begin
          rd_d[r*RSIZE +: RSIZE] = (BYPASS != 0) ? regs_d[i] : regs_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      rd_q        <= '0;
      rvalid_q    <= '0;
      wconflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      for (int r = 0; r < NRD; r++) begin
        if (re_i[r]) begin
          rd_q[r*RSIZE +: RSIZE] <= rd_d[r*RSIZE +: RSIZE];
        end
      end
      rvalid_q    <= re_i;
      wconflict_q <= conflict_d;
    end
  end

  assign rd_o        = rd_q;
  assign rvalid_o    = rvalid_q;
  assign wconflict_o = wconflict_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Randomised and directed bench for register_file_mp: two instances (write-first and
// read-first/zero-r0/6 regs) driven in parallel and compared against a reference model.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  we;
  logic [5:0]  widx;
  logic [31:0] wd;
  logic [3:0]  wbe;
  logic [1:0]  re;
  logic [5:0]  ridx;
  logic [31:0] rd_a, rd_b;
  logic [1:0]  rv_a, rv_b;
  logic        wc_a, wc_b;

  always #5 clk = ~clk;

  register_file_mp #(
    .NREGS(8), .RSIZE(16), .NRD(2), .NWR(2), .ZERO_R0(0), .BYPASS(1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .we_i(we), .widx_i(widx), .wd_i(wd), .wbe_i(wbe),
    .re_i(re), .ridx_i(ridx), .rd_o(rd_a), .rvalid_o(rv_a), .wconflict_o(wc_a)
  );

  register_file_mp #(
    .NREGS(6), .RSIZE(16), .NRD(2), .NWR(2), .ZERO_R0(1), .BYPASS(0)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .we_i(we), .widx_i(widx), .wd_i(wd), .wbe_i(wbe),
    .re_i(re), .ridx_i(ridx), .rd_o(rd_b), .rvalid_o(rv_b), .wconflict_o(wc_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model, one slot per instance.
  int         cfg_nregs [2] = '{8, 6};
  bit         cfg_zr0   [2] = '{1'b0, 1'b1};
  bit         cfg_byp   [2] = '{1'b1, 1'b0};
  logic [15:0] mem  [2][8];
  logic [15:0] m_rd [2][2];
  logic        m_rv [2][2];
  logic        m_wc [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mem[k][i] = '0;
      for (int r = 0; r < 2; r++) begin
        m_rd[k][r] = '0;
        m_rv[k][r] = 1'b0;
      end
      m_wc[k] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [15:0] nxt [8];
    int          cnt [8][2];
    int          ix;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        nxt[i]    = mem[k][i];
        cnt[i][0] = 0;
        cnt[i][1] = 0;
      end
      for (int p = 0; p < 2; p++) begin
        ix = int'(widx[p*3 +: 3]);
        if (we[p] && ix < cfg_nregs[k] && !(cfg_zr0[k] && ix == 0)) begin
          for (int b = 0; b < 2; b++) begin
            if (wbe[p*2 + b]) begin
              nxt[ix][b*8 +: 8] = wd[p*16 + b*8 +: 8];
              cnt[ix][b]++;
            end
          end
        end
      end
      m_wc[k] = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (cnt[i][0] > 1 || cnt[i][1] > 1) m_wc[k] = 1'b1;
      end
      for (int r = 0; r < 2; r++) begin
        ix = int'(ridx[r*3 +: 3]);
        m_rv[k][r] = re[r];
        if (re[r]) begin
          if (ix >= cfg_nregs[k] || (cfg_zr0[k] && ix == 0)) m_rd[k][r] = '0;
          else m_rd[k][r] = cfg_byp[k] ? nxt[ix] : mem[k][ix];
        end
      end
      for (int i = 0; i < 8; i++) mem[k][i] = nxt[i];
    end
  endtask

  task automatic compare_all();
    for (int r = 0; r < 2; r++) begin
      check($sformatf("a_rd%0d", r), rd_a[r*16 +: 16], m_rd[0][r]);
      check($sformatf("a_rv%0d", r), rv_a[r], m_rv[0][r]);
      check($sformatf("b_rd%0d", r), rd_b[r*16 +: 16], m_rd[1][r]);
      check($sformatf("b_rv%0d", r), rv_b[r], m_rv[1][r]);
    end
    check("a_wc", wc_a, m_wc[0]);
    check("b_wc", wc_b, m_wc[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    we  = '0;
    wbe = '0;
    re  = '0;
  endtask

  task automatic wr(input int p, input int idx, input logic [15:0] d, input logic [1:0] be);
    we[p]            = 1'b1;
    widx[p*3 +: 3]   = 3'(idx);
    wd[p*16 +: 16]   = d;
    wbe[p*2 +: 2]    = be;
  endtask

  task automatic rdp(input int r, input int idx);
    re[r]          = 1'b1;
    ridx[r*3 +: 3] = 3'(idx);
  endtask

  // Asserted and released between clock edges; outputs must clear without an edge.
  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    compare_all();
    #2;
    rst = 1'b0;
  endtask

  logic [1:0]  t3_be0 [3] = '{2'b11, 2'b11, 2'b01};
  logic [1:0]  t3_be1 [3] = '{2'b11, 2'b10, 2'b10};
  logic [15:0] t3_exp [3] = '{16'h5555, 16'h55AA, 16'h55AA};
  logic        t3_wc  [3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    idle();
    widx = '0;
    wd   = '0;
    ridx = '0;
    #2;
    do_reset();

    // Partial-byte overwrite.
    idle(); wr(0, 3, 16'hBEEF, 2'b11); cycle();
    idle(); wr(0, 3, 16'h1234, 2'b01); cycle();
    idle(); rdp(0, 3); cycle();
    check("t2_r3", rd_a[15:0], 16'hBE34);

    // Same-index multi-port writes.
    for (int v = 0; v < 3; v++) begin
      idle(); wr(0, 5, 16'hAAAA, t3_be0[v]); wr(1, 5, 16'h5555, t3_be1[v]); cycle();
      check($sformatf("t3_wc%0d", v), wc_a, t3_wc[v]);
      idle(); rdp(1, 5); cycle();
      check($sformatf("t3_r5_%0d", v), rd_a[31:16], t3_exp[v]);
      check($sformatf("t3_wc_clr%0d", v), wc_a, 1'b0);
    end

    // Read and write of the same index on one edge.
    idle(); wr(0, 2, 16'h1100, 2'b11); cycle();
    idle(); wr(1, 2, 16'h00FF, 2'b01); rdp(0, 2); cycle();
    check("t4_bypass", rd_a[15:0], 16'h11FF);
    check("t4_readfirst", rd_b[15:0], 16'h1100);
    check("t4_rv_a", rv_a[0], 1'b1);
    check("t4_rv_b", rv_b[0], 1'b1);

    // Hardwired r0 and out-of-range index.
    idle(); wr(0, 0, 16'hFFFF, 2'b11); wr(1, 0, 16'hFFFF, 2'b11); cycle();
    check("t5_wc_zr0", wc_b, 1'b0);
    check("t5_wc_r0", wc_a, 1'b1);
    idle(); rdp(0, 0); cycle();
    check("t5_r0_zero", rd_b[15:0], 16'h0000);
    check("t5_r0_norm", rd_a[15:0], 16'hFFFF);
    idle(); wr(0, 7, 16'hCAFE, 2'b11); cycle();
    idle(); rdp(1, 7); cycle();
    check("t5_oor_rd", rd_b[31:16], 16'h0000);
    check("t5_oor_rv", rv_b[1], 1'b1);
    check("t5_r7", rd_a[31:16], 16'hCAFE);

    // Streaming reads.
    for (int i = 0; i < 8; i++) begin
      idle(); wr(i % 2, i, 16'(i * 16'h0101), 2'b11); cycle();
    end
    for (int i = 0; i < 8; i++) begin
      idle(); rdp(0, i); rdp(1, (i + 3) % 8); cycle();
      check($sformatf("t6_p0_%0d", i), rd_a[15:0], 16'(i * 16'h0101));
      check($sformatf("t6_p1_%0d", i), rd_a[31:16], 16'(((i + 3) % 8) * 16'h0101));
    end
    idle(); rdp(0, 4); cycle();
    check("t6_hold", rd_a[31:16], 16'h0202);
    check("t6_rv1", rv_a[1], 1'b0);

    // Random traffic, indices biased low half the time to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      we  = 2'($urandom);
      wd  = $urandom;
      wbe = 4'($urandom);
      re  = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        widx[p*3 +: 3] = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 1))
                                                      : 3'($urandom_range(0, 7));
        ridx[p*3 +: 3] = 3'($urandom_range(0, 7));
      end
      cycle();
    end

    // Mid-run reset.
    idle(); rdp(0, 3); rdp(1, 5); cycle();
    check("t1_rv_pre", rv_a, 2'b11);
    #2;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle(); rdp(0, i); rdp(1, i); cycle();
      check($sformatf("t1_zero_%0d", i), rd_a, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
